// File: rtl/uart_frame_transmitter_pkg.sv
// Shared UART definitions: TX state encoding, line levels and parity selectors.
// The receiver checkers use the same constants.
package uart_frame_transmitter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_frame_transmitter_parity_bit_generator.sv
// Parity bit for a TX frame: XOR-reduce of the data, inverted for odd parity.
// TX counterpart of the receiver's parity_bit_checker.
module uart_frame_transmitter_parity_bit_generator #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  parity_type,
   output logic                  parity_bit
);

   assign parity_bit = (^data) ^ parity_type;

endmodule

// File: rtl/uart_frame_transmitter.sv
// UART frame transmitter: one-entry holding register feeding a start/data/parity/stop
// serializer, one clk per bit, registered line and busy outputs.
//
// state  | meaning
// IDLE   | line high; loads the holding register into the shifter when it is full
// START  | start bit (low) for one cycle
// DATA   | data bits LSB-first, bit_idx 0..DATA_WIDTH-1
// PARITY | parity bit captured at frame load
// STOP   | stop bit (high); chains straight into START when another byte is held
module uart_frame_transmitter
   import uart_frame_transmitter_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  parity_type,
   input  logic                  parity_enable,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] parallel_data,
   output logic                  data_ready,
   output logic                  serial_data,
   output logic                  busy
);

   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   tx_state_e             state, state_next;
   logic                  hold_full, hold_full_next;
   logic [DATA_WIDTH-1:0] hold_data;
   logic [DATA_WIDTH-1:0] shift_data;
   logic [IDX_W-1:0]      bit_idx, bit_idx_next;
   logic                  par_en_q;
   logic                  par_bit_q;
   logic                  par_bit_new;
   logic                  accept;
   logic                  load;
   logic                  line_next;

   uart_frame_transmitter_parity_bit_generator #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data        (hold_data),
      .parity_type (parity_type),
      .parity_bit  (par_bit_new)
   );

   // data_ready mirrors ~hold_full, so accept and load can never coincide
   assign accept = data_valid & data_ready;

   always_comb begin
      state_next   = state;
      bit_idx_next = bit_idx;
      load         = 1'b0;
      line_next    = IDLE_LEVEL;
      case (state)
         IDLE: begin
            line_next = IDLE_LEVEL;
            if (hold_full) begin
               load       = 1'b1;
               state_next = START;
            end
         end
         START: begin
            line_next    = START_BIT;
            bit_idx_next = '0;
            state_next   = DATA;
         end
         DATA: begin
            line_next = shift_data[bit_idx];
            if (bit_idx == LAST_IDX) begin
               state_next = par_en_q ? PARITY : STOP;
            end else begin
               bit_idx_next = bit_idx + 1'b1;
            end
         end
         PARITY: begin
            line_next  = par_bit_q;
            state_next = STOP;
         end
         STOP: begin
            line_next = STOP_BIT;
            if (hold_full) begin
               load       = 1'b1;
               state_next = START;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      hold_full_next = hold_full;
      if (accept) begin
         hold_full_next = 1'b1;
      end else if (load) begin
         hold_full_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         hold_full   <= 1'b0;
         hold_data   <= '0;
         shift_data  <= '0;
         bit_idx     <= '0;
         par_en_q    <= 1'b0;
         par_bit_q   <= 1'b0;
         data_ready  <= 1'b1;
         serial_data <= IDLE_LEVEL;
         busy        <= 1'b0;
      end else begin
         state       <= state_next;
         hold_full   <= hold_full_next;
         data_ready  <= ~hold_full_next;
         bit_idx     <= bit_idx_next;
         // outputs lag the state by one cycle so the line comes straight off a flop
         serial_data <= line_next;
         busy        <= (state != IDLE);
         if (accept) begin
            hold_data <= parallel_data;
         end
         if (load) begin
            shift_data <= hold_data;
            par_en_q   <= parity_enable;
            par_bit_q  <= par_bit_new;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Scoreboard bench for uart_frame_transmitter: stimulus queues expected line frames,
// a monitor decodes the line and compares bit by bit.
module tb_uart_frame_transmitter;

   typedef struct {
      logic [15:0] bits;   // line bits, first-sent bit at index len-1
      int          len;
   } frame_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       parity_type = 1'b0;
   logic       parity_enable = 1'b0;
   logic       data_valid = 1'b0;
   logic [7:0] parallel_data = 8'h00;
   logic       data_ready;
   logic       serial_data;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   frame_t exp_q[$];
   frame_t cur;
   bit     in_frame = 1'b0;
   int     mon_pos = 0;
   int     busy_run = 0;
   int     last_run = 0;
   int     ready_falls = 0;
   logic   ready_prev = 1'b1;

   uart_frame_transmitter #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .parity_type   (parity_type),
      .parity_enable (parity_enable),
      .data_valid    (data_valid),
      .parallel_data (parallel_data),
      .data_ready    (data_ready),
      .serial_data   (serial_data),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic frame_t build(input logic [7:0] d, input logic pen, input logic pt);
      frame_t f;
      f.bits = '0;
      f.len  = 0;
      f.bits = {f.bits[14:0], 1'b0};
      f.len++;
      for (int i = 0; i < 8; i++) begin
         f.bits = {f.bits[14:0], d[i]};
         f.len++;
      end
      if (pen) begin
         f.bits = {f.bits[14:0], (^d) ^ pt};
         f.len++;
      end
      f.bits = {f.bits[14:0], 1'b1};
      f.len++;
      return f;
   endfunction

   // line monitor / scoreboard
   always @(negedge clk) begin
      if (reset) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         if (serial_data === 1'b0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_start", 32'(serial_data), 32'h1);
            end else begin
               cur      = exp_q.pop_front();
               in_frame = 1'b1;
               mon_pos  = 0;
               check("start_busy", 32'(busy), 32'h1);
            end
         end
      end else begin
         mon_pos++;
         check($sformatf("frame_bit%0d", mon_pos), 32'(serial_data), 32'(cur.bits[cur.len-1-mon_pos]));
         check("frame_busy", 32'(busy), 32'h1);
         if (mon_pos == cur.len - 1) in_frame = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (busy === 1'b1) begin
         busy_run++;
      end else if (busy_run > 0) begin
         last_run = busy_run;
         busy_run = 0;
      end
      if (ready_prev === 1'b1 && data_ready === 1'b0) ready_falls++;
      ready_prev = data_ready;
   end

   task automatic send(input logic [7:0] d, input frame_t f, input bit hold);
      bit acc;
      bit done;
      exp_q.push_back(f);
      data_valid    = 1'b1;
      parallel_data = d;
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         acc = data_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("accept_timeout", 32'h0, 32'h1);
      if (!hold) data_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (!busy && !in_frame && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 32'h0, 32'h1);
      repeat (2) @(negedge clk);
      #1;
   endtask

   function automatic frame_t mk(input logic [15:0] bits, input int len);
      frame_t f;
      f.bits = bits;
      f.len  = len;
      return f;
   endfunction

   initial begin
      bit ok;
      logic [7:0] rd;
      logic       rpen, rpt;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_serial", 32'(serial_data), 32'h1);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ready", 32'(data_ready), 32'h1);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // A5, parity off: 0 10100101 1
      parity_enable = 1'b0;
      send(8'hA5, mk(16'b0101001011, 10), 1'b0);
      wait_idle();
      check("a5_busy_len", 32'(last_run), 32'd10);
      check("a5_idle_line", 32'(serial_data), 32'h1);

      // A5 even parity -> parity bit 0
      parity_enable = 1'b1;
      parity_type   = 1'b0;
      send(8'hA5, mk(16'b01010010101, 11), 1'b0);
      wait_idle();
      check("a5_even_len", 32'(last_run), 32'd11);

      // A5 odd parity -> parity bit 1
      parity_type = 1'b1;
      send(8'hA5, mk(16'b01010010111, 11), 1'b0);
      wait_idle();
      check("a5_odd_len", 32'(last_run), 32'd11);

      // 00 then FF back-to-back with valid held high
      parity_enable = 1'b0;
      parity_type   = 1'b0;
      ready_falls   = 0;
      send(8'h00, mk(16'b0000000001, 10), 1'b1);
      send(8'hFF, mk(16'b0111111111, 10), 1'b0);
      wait_idle();
      check("b2b_busy_len", 32'(last_run), 32'd20);
      check("b2b_ready_pulses", 32'(ready_falls), 32'd2);

      // reset during the 4th data bit of 3C
      send(8'h3C, build(8'h3C, 1'b0, 1'b0), 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (in_frame && mon_pos == 4) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("rst_mid_timeout", 32'h0, 32'h1);
      reset         = 1'b1;
      data_valid    = 1'b1;
      parallel_data = 8'hEE;
      @(posedge clk);
      #1;
      check("midrst_serial", 32'(serial_data), 32'h1);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_ready", 32'(data_ready), 32'h1);
      @(negedge clk);
      #1;
      reset      = 1'b0;
      data_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("rst_accept_ignored", 32'(busy), 32'h0);
      check("rst_line_idle", 32'(serial_data), 32'h1);
      // fresh byte after abort: 0 01011010 1
      send(8'h5A, mk(16'b0010110101, 10), 1'b0);
      wait_idle();
      check("post_rst_len", 32'(last_run), 32'd10);

      // parity_enable toggled mid-frame: 81 keeps parity, 0F goes without
      parity_enable = 1'b1;
      parity_type   = 1'b0;
      send(8'h81, mk(16'b01000000101, 11), 1'b0);
      repeat (3) @(negedge clk);
      parity_enable = 1'b0;
      parity_type   = 1'b1;
      send(8'h0F, mk(16'b0111100001, 10), 1'b0);
      wait_idle();
      check("toggle_busy_len", 32'(last_run), 32'd21);

      // assorted bytes and parity settings
      for (int i = 0; i < 6; i++) begin
         rd   = 8'($urandom_range(0, 255));
         rpen = 1'($urandom_range(0, 1));
         rpt  = 1'($urandom_range(0, 1));
         parity_enable = rpen;
         parity_type   = rpt;
         send(rd, build(rd, rpen, rpt), 1'b0);
         wait_idle();
         check("rand_len", 32'(last_run), 32'(10 + int'(rpen)));
      end

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/uart_frame_transmitter.md
Name: uart_frame_transmitter

Overview:
- Serial transmitter matching the UART receiver: accepts parallel bytes over a valid/ready handshake and emits start bit, DATA_WIDTH data bits LSB-first, optional parity bit, and stop bit.
- Runs on the UART TX clock, one clk cycle per bit; the receiver oversamples this by prescale.
- Has a one-entry holding register, so the next byte can be accepted while the current frame shifts out. This gives back-to-back frames with no idle bit between them.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (>= 2).

Ports:
- clk  input  1  UART TX clock; one bit period per cycle.
- reset  input  1  synchronous, active-high reset.
- parity_type  input  1  1 = odd parity, 0 = even parity.
- parity_enable  input  1  1 = insert a parity bit between the data bits and the stop bit.
- data_valid  input  1  parallel_data is valid this cycle.
- parallel_data  input  DATA_WIDTH  byte to transmit.
- data_ready  output  1  holding register is empty; a byte is accepted when data_valid & data_ready.
- serial_data  output  1  TX line; idles high.
- busy  output  1  high while a frame (start through stop) is on the line.

Behaviour:
- Reset (synchronous, active-high; dominates all other inputs, including mid-frame):
  - State goes to IDLE, holding register is cleared.
  - serial_data=1, busy=0, data_ready=1.
  - A frame in progress is abandoned and the line returns high on the next cycle.
- Handshake:
  - A byte is accepted on a rising clk edge with data_valid=1 and data_ready=1.
  - The byte is copied into the holding register and the hold flag is set.
  - data_ready = ~hold_full, registered.
  - data_valid with data_ready=0 is ignored; the source must hold the byte until accepted.
- Config latch: parity_type and parity_enable are captured when a frame starts (holding register moves to shift register). Changes mid-frame do not affect that frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: serial_data=1. If hold_full, load the shift register, clear hold_full, compute the parity bit, go to START.
  - START: serial_data=0 for one cycle, then DATA with bit index 0.
  - DATA: serial_data=shift[index]. The index counter is $clog2(DATA_WIDTH) wide. After index DATA_WIDTH-1, go to PARITY if the latched parity_enable is 1, else STOP.
  - PARITY: serial_data = ^data XOR parity_type, i.e. even gives an even total count of ones and odd gives an odd count. One cycle, then STOP.
  - STOP: serial_data=1 for one cycle. If hold_full, load the next byte (same actions as IDLE) and go straight to START. Otherwise go to IDLE.
- serial_data and busy are registered outputs, so there are no glitches on the line.
- busy is 1 in START/DATA/PARITY/STOP and 0 in IDLE.
- Latency:
  - A byte accepted at edge N while IDLE is loaded at edge N+1, start bit appears after edge N+2.
  - Frame length is 2+DATA_WIDTH (+1 with parity) cycles.
- Simultaneous events:
  - Accept in the same cycle the STOP/IDLE load empties the holding register: not possible, since data_ready was 0 while full.
  - The register refills on the edge after it empties, so a continuous valid stream has no idle cycles between frames.
- Accept during reset: ignored.

Decomposition:
- Shared UART package holds:
  - TX state encoding: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4.
  - Line levels: START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - Parity type constants: EVEN=0, ODD=1.
  - These are shared with the receiver checkers.
- Natural sub-module: parity_bit_generator (combinational XOR-reduce plus parity_type), the TX mirror of parity_bit_checker.
- The FSM, holding register and serializer stay in the top module.

Test Plan:
- Reset, then byte 8'hA5 with parity off -> line 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), busy high for 10 cycles, then idle high.
- 8'hA5 with even parity -> parity bit 0; with odd parity -> parity bit 1; frame is 11 cycles.
- Bytes 8'h00 then 8'hFF presented back-to-back with data_valid held high -> second start bit immediately follows the first stop bit, and data_ready pulses low/high exactly once per frame.
- Assert reset during the 4th data bit of 8'h3C -> next cycle serial_data=1, busy=0, data_ready=1; a fresh byte then transmits a correct full frame.
- Toggle parity_enable mid-frame -> current frame keeps its latched setting (length unchanged), and the next frame uses the new setting.
- Loopback into the UART receiver at prescale 8, 16 and 32 with random bytes and parity settings -> receiver data_valid each frame, parallel_data matches, parity_error=0, frame_error=0.
